pixel_plot_sink: RTL and testbench
==================================

// Module: pixel_plot_sink
// PURPOSE
//  Consumer end of the pixel-plot interface that the character/animation blocks drive (X, Y, colour, plot strobe).
//  Accepts plot requests through a valid/ready handshake and buffers them in a small FIFO.
//  Converts each request to a linear framebuffer write (addr = Y*WIDTH + X).
//  Also performs full-screen clears on command, stalling new requests until the sweep completes.
// PARAMETERS
//  WIDTH       160   screen width in pixels; legal X is 0..WIDTH-1
//  HEIGHT      120   screen height in pixels; legal Y is 0..HEIGHT-1
//  FIFO_DEPTH  4     request FIFO entries, power of 2, >=2
//  ADDR_W      15    framebuffer address width; must satisfy WIDTH*HEIGHT <= 2**ADDR_W
// PORTS
//  iClock       in   1       system clock; all logic on posedge
//  iReset       in   1       asynchronous, active-high reset
//  iX           in   8       request X coordinate
//  iY           in   7       request Y coordinate
//  iColour      in   3       request colour (0-7)
//  iValid       in   1       request present; accepted on an edge where iValid && oReady
//  oReady       out  1       sink can accept a request this cycle
//  iClear       in   1       clear command; sampled on each edge
//  iClearColour in   3       fill colour; captured with iClear
//  oBusy        out  1       clear pending or in progress
//  oMemAddr     out  ADDR_W  framebuffer write address (registered)
//  oMemData     out  3       framebuffer write colour (registered)
//  oMemWe       out  1       framebuffer write enable, one cycle per pixel (registered)
//  oDropped     out  1       one-cycle pulse: popped request was off-screen and discarded
//  oCount       out  3       current FIFO occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (async, iReset=1):
//   - oMemAddr=0, oMemData=0, oMemWe=0, oDropped=0, oBusy=0, oCount=0.
//   - FIFO emptied, pending clear discarded, FSM=RUN.
//   - oReady forced to 0 while iReset is high.
//  oReady (combinational) = !iReset && state==RUN && !clear_pending && oCount<FIFO_DEPTH.
//  FSM has two states: RUN and CLEAR.
//  RUN:
//   - One FIFO entry is popped per cycle while the FIFO is non-empty, giving a throughput of 1 pixel/clk.
//   - Latency: a request accepted on edge k produces oMemWe=1 with its addr/data after edge k+1 when the FIFO was empty.
//   - Ordering is strictly FIFO.
//   - Push and pop on the same edge are legal; the count is unchanged.
//   - Address is computed as iY*WIDTH + iX in ADDR_W bits with no truncation (max value 19199).
//   - Off-screen request (X>=WIDTH or Y>=HEIGHT): it is popped, oMemWe stays 0, and oDropped pulses for 1 cycle in the slot its write would occupy.
//  iClear in RUN:
//   - Sets clear_pending and captures iClearColour.
//   - oBusy=1 and oReady=0 from the next cycle.
//   - The FIFO drains normally.
//   - When the FIFO is empty, the FSM moves to CLEAR.
//  iValid && iClear on the same edge: the request is accepted and written before the sweep, so it is erased.
//  CLEAR:
//   - Writes addresses 0..WIDTH*HEIGHT-1 in order, one per cycle, oMemWe=1, oMemData=captured colour.
//   - After the last address, returns to RUN: oBusy=0 and oReady=1 on the following cycle.
//  iClear while oBusy=1: ignored; the captured colour is unchanged.
//  Reset mid-sweep or mid-drain: outputs go to their reset values immediately, with no further writes after reset is released.
//  oMemWe is never high for two different pixels in the same cycle; addr/data are held stable whenever oMemWe=0.
// TESTING
//  1. Release reset, then one request X=5,Y=3,colour=4 -> exactly one oMemWe pulse after edge k+1, addr=485, data=4; oCount returns to 0.
//  2. Ten back-to-back requests with iValid held high -> oReady stays 1; ten consecutive oMemWe cycles in input order; oCount never exceeds 1.
//  3. Requests (160,0) and (0,120), then (159,119) colour 7 -> two oDropped pulses with no writes, then addr=19199, data=7.
//  4. Preload 3 entries, then iClear with colour 1 -> the 3 pixels are written first, then 19200 writes addr 0..19199 data 1; oReady=0 and oBusy=1 throughout.
//  5. iValid (10,10,colour 2) and iClear (colour 0) on the same edge -> addr 1610 written with data 2, then the full sweep with data 0.
//  6. Assert iReset asynchronously mid-sweep at addr ~1000 -> oMemWe, oBusy, oCount drop to 0 without waiting for an edge; after release oReady=1 and no writes occur.

Source files
------------

// File: rtl/pixel_plot_sink.sv
// Pixel-plot sink: buffers plot requests in a small FIFO, turns each into a linear framebuffer
// write, and performs full-screen clears that stall new requests until the sweep completes.
module pixel_plot_sink #(
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned HEIGHT     = 120,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [7:0]        iX,
    input  logic [6:0]        iY,
    input  logic [2:0]        iColour,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iClear,
    input  logic [2:0]        iClearColour,
    output logic              oBusy,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [2:0]        oMemData,
    output logic              oMemWe,
    output logic              oDropped,
    output logic [2:0]        oCount
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SW_W  = ADDR_W + 1;
    localparam logic [2:0]      DEPTH_C = 3'(FIFO_DEPTH);
    localparam logic [SW_W-1:0] TOTAL_C = SW_W'(WIDTH * HEIGHT);

    typedef enum logic [0:0] {StRun, StClear} state_e;

    state_e            r_state;
    state_e            w_state_d;

    // Entry layout: {x[7:0], y[6:0], colour[2:0]}
    logic [17:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [2:0]        r_count;
    logic [2:0]        w_count_d;

    logic              r_clear_pending;
    logic [2:0]        r_clear_colour;
    logic [SW_W-1:0]   r_sweep;

    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_data;
    logic              r_we;
    logic              r_dropped;

    logic [ADDR_W-1:0] w_addr_d;
    logic [2:0]        w_data_d;
    logic              w_we_d;
    logic              w_dropped_d;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic [17:0]       w_head;
    logic [7:0]        w_hx;
    logic [6:0]        w_hy;
    logic [2:0]        w_hc;
    logic              w_onscreen;
    logic [ADDR_W-1:0] w_pix_addr;
    logic              w_sweep_done;

    assign w_ready = !iReset && (r_state == StRun) && !r_clear_pending && (r_count < DEPTH_C);
    assign w_push  = iValid && w_ready;
    assign w_pop   = (r_state == StRun) && (r_count != 3'd0);

    assign w_head       = r_fifo[r_rd_ptr];
    assign w_hx         = w_head[17:10];
    assign w_hy         = w_head[9:3];
    assign w_hc         = w_head[2:0];
    assign w_onscreen   = (32'(w_hx) < WIDTH) && (32'(w_hy) < HEIGHT);
    assign w_pix_addr   = ADDR_W'(w_hy) * ADDR_W'(WIDTH) + ADDR_W'(w_hx);
    assign w_sweep_done = (r_sweep == TOTAL_C);

    always_comb begin
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + 3'd1;
            2'b01:   w_count_d = r_count - 3'd1;
            default: w_count_d = r_count;
        endcase
    end

    // FSM state register
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next state: the FIFO must be fully drained before the sweep starts
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StRun:   if (r_clear_pending && (r_count == 3'd0)) w_state_d = StClear;
            StClear: if (w_sweep_done) w_state_d = StRun;
            default: w_state_d = StRun;
        endcase
    end

    // FSM outputs: next values of the registered write port
    always_comb begin
        w_we_d      = 1'b0;
        w_dropped_d = 1'b0;
        w_addr_d    = r_addr;
        w_data_d    = r_data;
        unique case (r_state)
            StRun: begin
                if (w_pop) begin
                    if (w_onscreen) begin
                        w_we_d   = 1'b1;
                        w_addr_d = w_pix_addr;
                        w_data_d = w_hc;
                    end else begin
                        w_dropped_d = 1'b1;
                    end
                end
            end
            StClear: begin
                if (!w_sweep_done) begin
                    w_we_d   = 1'b1;
                    w_addr_d = r_sweep[ADDR_W-1:0];
                    w_data_d = r_clear_colour;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {iX, iY, iColour};
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_clear_pending <= 1'b0;
            r_clear_colour  <= '0;
            r_sweep         <= '0;
            r_addr          <= '0;
            r_data          <= '0;
            r_we            <= 1'b0;
            r_dropped       <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_d;

            // A clear arriving while one is already pending is ignored
            if ((r_state == StRun) && !r_clear_pending && iClear) begin
                r_clear_pending <= 1'b1;
                r_clear_colour  <= iClearColour;
            end else if ((r_state == StClear) && w_sweep_done) begin
                r_clear_pending <= 1'b0;
            end

            if (r_state == StRun) begin
                r_sweep <= '0;
            end else if (!w_sweep_done) begin
                r_sweep <= r_sweep + SW_W'(1);
            end

            r_addr    <= w_addr_d;
            r_data    <= w_data_d;
            r_we      <= w_we_d;
            r_dropped <= w_dropped_d;
        end
    end

    assign oReady   = w_ready;
    assign oBusy    = r_clear_pending;
    assign oMemAddr = r_addr;
    assign oMemData = r_data;
    assign oMemWe   = r_we;
    assign oDropped = r_dropped;
    assign oCount   = r_count;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboard bench for pixel_plot_sink: stimulus pushes expected writes/drops into a queue,
// a negedge monitor pops and compares whenever the sink emits a write or a drop pulse.
module tb_pixel_plot_sink;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic [7:0]  iX = '0;
    logic [6:0]  iY = '0;
    logic [2:0]  iColour = '0;
    logic        iValid = 1'b0;
    logic        oReady;
    logic        iClear = 1'b0;
    logic [2:0]  iClearColour = '0;
    logic        oBusy;
    logic [14:0] oMemAddr;
    logic [2:0]  oMemData;
    logic        oMemWe;
    logic        oDropped;
    logic [2:0]  oCount;

    pixel_plot_sink #(
        .WIDTH(160), .HEIGHT(120), .FIFO_DEPTH(4), .ADDR_W(15)
    ) dut (
        .iClock(iClock), .iReset(iReset), .iX(iX), .iY(iY), .iColour(iColour),
        .iValid(iValid), .oReady(oReady), .iClear(iClear), .iClearColour(iClearColour),
        .oBusy(oBusy), .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemWe(oMemWe),
        .oDropped(oDropped), .oCount(oCount)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        bit          drop;
        bit          sweep;
        logic [14:0] addr;
        logic [2:0]  data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   max_cnt  = 0;
    int   stalls   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Monitor
    always @(negedge iClock) begin
        if (!iReset) begin
            if (32'(oCount) > max_cnt) max_cnt = 32'(oCount);
            if (oMemWe || oDropped) begin
                check("we_and_drop_exclusive", 32'(oMemWe && oDropped), 0);
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("drop_flag", 32'(oDropped), 32'(e.drop));
                    if (!e.drop) begin
                        check("addr", 32'(oMemAddr), 32'(e.addr));
                        check("data", 32'(oMemData), 32'(e.data));
                    end
                    if (e.sweep && (e.addr[7:0] == 8'd0)) begin
                        check("busy_ready_in_sweep", 32'({oBusy, oReady}), 32'(2'b10));
                    end
                end
            end
        end
    end

    task automatic expect_pix(input logic [14:0] addr, input logic [2:0] data, input bit drop);
        exp_t e;
        e.drop = drop; e.sweep = 1'b0; e.addr = addr; e.data = data;
        q.push_back(e);
    endtask

    task automatic expect_sweep(input int last, input logic [2:0] data);
        for (int a = 0; a <= last; a++) begin
            exp_t e;
            e.drop = 1'b0; e.sweep = 1'b1; e.addr = 15'(a); e.data = data;
            q.push_back(e);
        end
    endtask

    // Drive one request from the next negedge; it is accepted on the following posedge
    task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                        input logic [14:0] addr, input bit drop);
        int waited;
        @(negedge iClock);
        iValid = 1'b1; iX = x; iY = y; iColour = c;
        #1;
        waited = 0;
        while (!oReady && waited < 40000) begin
            @(negedge iClock); #1;
            waited++;
            stalls++;
        end
        if (!oReady) check("send_timeout", 0, 1);
        expect_pix(addr, c, drop);
    endtask

    task automatic idle(input int n);
        @(negedge iClock);
        iValid = 1'b0; iClear = 1'b0;
        repeat (n) @(negedge iClock);
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((oBusy || oCount != 0) && t < budget) begin
            @(negedge iClock);
            t++;
        end
        check("idle_reached", 32'(oBusy || oCount != 0), 0);
        repeat (3) @(negedge iClock);
        check("queue_drained", 32'(q.size()), 0);
        check("ready_after_idle", 32'(oReady), 1);
    endtask

    initial begin
        #2;
        check("rst_we", 32'(oMemWe), 0);
        check("rst_ready", 32'(oReady), 0);
        check("rst_busy", 32'(oBusy), 0);
        check("rst_count", 32'(oCount), 0);
        check("rst_addr", 32'(oMemAddr), 0);
        check("rst_drop", 32'(oDropped), 0);
        #10 iReset = 1'b0;

        // 1: single request, latency k+1
        send(8'd5, 7'd3, 3'd4, 15'd485, 1'b0);
        @(negedge iClock);
        iValid = 1'b0;
        check("t1_no_we_after_k", 32'(oMemWe), 0);
        check("t1_count_after_k", 32'(oCount), 1);
        @(negedge iClock);
        check("t1_we_after_k1", 32'(oMemWe), 1);
        check("t1_count_zero", 32'(oCount), 0);
        idle(3);

        // 2: ten back-to-back requests
        stalls = 0; max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'(3 * i), 7'(i), 3'(i), 15'(163 * i), 1'b0);
        end
        idle(4);
        check("t2_no_stalls", 32'(stalls), 0);
        check("t2_max_count", 32'(max_cnt), 1);
        check("t2_queue_empty", 32'(q.size()), 0);

        // 3: off-screen drops, then the last on-screen pixel
        send(8'd160, 7'd0, 3'd3, 15'd0, 1'b1);
        send(8'd0, 7'd120, 3'd5, 15'd0, 1'b1);
        send(8'd159, 7'd119, 3'd7, 15'd19199, 1'b0);
        idle(4);
        check("t3_queue_empty", 32'(q.size()), 0);

        // 4: three requests then a clear; a second clear mid-sweep is ignored
        send(8'd1, 7'd0, 3'd2, 15'd1, 1'b0);
        send(8'd2, 7'd1, 3'd3, 15'd162, 1'b0);
        send(8'd3, 7'd2, 3'd6, 15'd323, 1'b0);
        @(negedge iClock);
        iValid = 1'b0; iClear = 1'b1; iClearColour = 3'd1;
        expect_sweep(19199, 3'd1);
        @(negedge iClock);
        iClear = 1'b0;
        check("t4_busy", 32'(oBusy), 1);
        check("t4_not_ready", 32'(oReady), 0);
        repeat (200) @(negedge iClock);
        iClear = 1'b1; iClearColour = 3'd6;
        @(negedge iClock);
        iClear = 1'b0;
        wait_idle(25000);

        // 5: request and clear on the same edge
        @(negedge iClock);
        iValid = 1'b1; iX = 8'd10; iY = 7'd10; iColour = 3'd2;
        iClear = 1'b1; iClearColour = 3'd0;
        #1;
        check("t5_ready", 32'(oReady), 1);
        expect_pix(15'd1610, 3'd2, 1'b0);
        expect_sweep(19199, 3'd0);
        @(negedge iClock);
        iValid = 1'b0; iClear = 1'b0;
        wait_idle(25000);

        // 6: asynchronous reset mid-sweep
        @(negedge iClock);
        iClear = 1'b1; iClearColour = 3'd5;
        expect_sweep(999, 3'd5);
        @(negedge iClock);
        iClear = 1'b0;
        begin
            int t;
            t = 0;
            while (!(oMemWe && oMemAddr == 15'd999) && t < 3000) begin
                @(negedge iClock);
                t++;
            end
            check("t6_reached_999", 32'(oMemWe && oMemAddr == 15'd999), 1);
        end
        #2 iReset = 1'b1;
        #1;
        check("t6_we_async", 32'(oMemWe), 0);
        check("t6_busy_async", 32'(oBusy), 0);
        check("t6_count_async", 32'(oCount), 0);
        check("t6_ready_in_reset", 32'(oReady), 0);
        check("t6_queue_empty", 32'(q.size()), 0);
        @(negedge iClock);
        #2 iReset = 1'b0;
        #1;
        check("t6_ready_after", 32'(oReady), 1);
        repeat (30) @(negedge iClock);
        check("t6_no_writes", 32'(q.size()), 0);
        check("t6_busy_after", 32'(oBusy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
